// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU issue unit.
// Holds the ALU operation codes driven to the 32-bit ALU, the main-control
// ALUOp class encodings, the R-type funct values the unit understands,
// the EX result-mux select encodings and the multiply FSM state type.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_SLT = 3'b100
    } alu_signal_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    typedef enum logic [1:0] {
        HILO_ALU = 2'b00,
        HILO_HI  = 2'b01,
        HILO_LO  = 2'b10
    } hilo_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mul_state_e;

endpackage

// File: rtl/multu_seq.sv
// Unsigned shift-add multiply sequencer with the HI/LO registers.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           capture operands and begin a WIDTH-step multiply
//   multiplicand    operand added into the upper accumulator half
//   multiplier      operand loaded into the lower accumulator half
//   last            high during the final step; HI/LO load at that edge
//   hi, lo          full 2*WIDTH-bit product of the last completed multiply
module multu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             running_q, running_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   step_sum;

    // P_hi carries one extra bit so the add never loses its carry before
    // the shift folds it back into the product.
    always_comb begin
        mcand_d   = mcand_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        count_d   = count_q;
        running_d = running_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        step_sum  = p_hi_q + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
        last      = running_q && (count_q == LAST_COUNT);

        if (start) begin
            mcand_d   = multiplicand;
            p_hi_d    = '0;
            p_lo_d    = multiplier;
            count_d   = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            p_hi_d  = {1'b0, step_sum[WIDTH:1]};
            p_lo_d  = {step_sum[0], p_lo_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
            if (last) begin
                running_d = 1'b0;
                hi_d      = step_sum[WIDTH:1];
                lo_d      = {step_sum[0], p_lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            mcand_q   <= mcand_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            count_q   <= count_d;
            running_q <= running_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_issue.sv
// EX-stage ALU issue unit: decodes ALUOp/funct into the ALU operation code
// and result-mux select, and sequences MULTU through multu_seq while
// stalling the pipeline.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   in_valid          ID/EX holds a valid instruction
//   alu_op, funct     main-control class and R-type function field
//   src_a, src_b      forwarded operands (MULTU multiplicand / multiplier)
//   alu_signal        ALU operation code
//   hilo_sel          EX result mux select (ALU / HI / LO)
//   illegal           valid R-type with an unsupported funct
//   stall             hold IF/ID/EX and bubble MEM
//   mul_done          one-cycle pulse in the cycle after HI/LO update
//   hi, lo            HI/LO registers
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [2:0]       alu_signal,
    output logic [1:0]       hilo_sel,
    output logic             illegal,
    output logic             stall,
    output logic             mul_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alu_signal_e sig;
    hilo_sel_e   sel;
    logic        illegal_funct;
    logic        multu_req;
    logic        seq_start;
    logic        seq_last;
    mul_state_e  state_q, state_d;
    logic        mul_done_q, mul_done_d;

    always_comb begin
        sig           = ALU_ADD;
        sel           = HILO_ALU;
        illegal_funct = 1'b0;
        case (alu_op)
            ALUOP_MEM:    sig = ALU_ADD;
            ALUOP_BRANCH: sig = ALU_SUB;
            ALUOP_RSVD:   sig = ALU_ADD;
            default: begin
                case (funct)
                    FUNCT_ADD:   sig = ALU_ADD;
                    FUNCT_SUB:   sig = ALU_SUB;
                    FUNCT_AND:   sig = ALU_AND;
                    FUNCT_OR:    sig = ALU_OR;
                    FUNCT_SLT:   sig = ALU_SLT;
                    FUNCT_MFHI:  sel = HILO_HI;
                    FUNCT_MFLO:  sel = HILO_LO;
                    FUNCT_MULTU: sig = ALU_ADD;
                    default:     illegal_funct = 1'b1;
                endcase
            end
        endcase
    end

    assign alu_signal = sig;
    assign hilo_sel   = sel;
    assign illegal    = in_valid && illegal_funct;
    assign multu_req  = in_valid && (alu_op == ALUOP_RTYPE) && (funct == FUNCT_MULTU);

    // In DONE the finished MULTU is still sitting in EX; it must not be
    // accepted again, so only IDLE may start the sequencer.
    always_comb begin
        state_d    = state_q;
        mul_done_d = 1'b0;
        seq_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (multu_req) begin
                    seq_start = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (seq_last) begin
                    state_d    = ST_DONE;
                    mul_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mul_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_done_q <= mul_done_d;
        end
    end

    // Reset must release the pipeline immediately even while the MULTU
    // that was in flight is still presented on the inputs.
    assign stall    = !rst && (((state_q == ST_IDLE) && multu_req) || (state_q == ST_BUSY));
    assign mul_done = mul_done_q;

    multu_seq #(
        .WIDTH(WIDTH)
    ) u_multu_seq (
        .clk          (clk),
        .rst          (rst),
        .start        (seq_start),
        .multiplicand (src_a),
        .multiplier   (src_b),
        .last         (seq_last),
        .hi           (hi),
        .lo           (lo)
    );

endmodule

// File: doc/alu_issue.md
# alu_issue

EX-stage ALU issue unit for the pipelined MIPS-Lite CPU: the initiator side of the 32-bit ALU's 3-bit operation interface. It decodes ALUOp/funct into the ALU `signal` code and result-select. It also owns the HI/LO registers and a 32-iteration shift-add sequencer for MULTU, stalling the pipeline while a multiply runs. It sits between the ID/EX pipeline register and the ALU/EX result mux.

## Interface
Parameters:
- `WIDTH`, 32: operand width; multiply iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  ID/EX holds a valid instruction.
- `alu_op`  in  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- `funct`  in  6  R-type function field.
- `src_a`, `src_b`  in  WIDTH  forwarded EX operands; `src_a` is the MULTU multiplicand, `src_b` the multiplier.
- `alu_signal`  out  3  ALU operation code: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT.
- `hilo_sel`  out  2  EX result mux: 00 ALU, 01 HI, 10 LO.
- `illegal`  out  1  valid R-type with unsupported funct.
- `stall`  out  1  hold IF/ID/EX, bubble MEM.
- `mul_done`  out  1  one-cycle pulse when HI/LO update.
- `hi`, `lo`  out  WIDTH  HI/LO registers.

## Operation
- Decode is combinational, zero latency:
  - `alu_op` 00 → ADD.
  - `alu_op` 01 → SUB.
  - `alu_op` 11 → ADD, `illegal`=0.
  - `alu_op` 10, by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x10 MFHI (`hilo_sel`=01), 0x12 MFLO (10), 0x19 MULTU.
  - Any other funct → ADD, with `illegal`=in_valid.
  - `hilo_sel`=00 except for MFHI/MFLO.
- FSM states IDLE, BUSY, DONE:
  - IDLE: a valid MULTU makes `stall`=1 combinationally. At the edge, the unit captures `src_a`/`src_b`, clears the accumulator, sets count=0 and goes to BUSY.
  - BUSY: `stall`=1. Each cycle performs one shift-add step and increments count. At the edge with count==WIDTH-1, it writes HI/LO and goes to DONE.
  - DONE: `stall`=0 and `mul_done`=1. The MULTU still in EX is ignored and never restarts. The next edge returns to IDLE.
- Arithmetic is unsigned:
  - Accumulator is {P_hi (WIDTH+1 bits, carry), P_lo (WIDTH)}, with P_lo loaded with the multiplier.
  - Each step: if P_lo[0], P_hi += multiplicand; then the whole accumulator shifts right 1.
  - Final HI = P_hi[WIDTH-1:0] and LO = P_lo, i.e. the full 2·WIDTH-bit product with no truncation.
- MFHI/MFLO read the registered `hi`/`lo`. No HI/LO forwarding is needed because the pipeline is stalled until the write.
- Reset, at any time including mid-BUSY: state IDLE, count 0, accumulator 0, `hi`=`lo`=0, `mul_done`=0, `stall`=0. Combinational outputs follow the inputs.

## Timing
- `alu_signal`, `hilo_sel` and `illegal` are valid in the same cycle as the inputs.
- MULTU timing:
  - `stall` is high for WIDTH+1 consecutive cycles: the accept cycle plus WIDTH BUSY cycles.
  - The instruction leaves EX at the edge ending DONE.
  - `hi`/`lo` are updated at the edge entering DONE.
- A back-to-back MULTU is accepted in the first IDLE cycle after DONE, so there is no gap stall.
- Flush is handled upstream: the pipeline is stalled while BUSY, so no flush can reach a BUSY unit.

## Structure
- Shared package `alu_pkg` holds:
  - ALU signal codes.
  - `alu_op` encodings.
  - funct constants.
  - `hilo_sel` encodings.
  - FSM state typedef.
- Sub-module `multu_seq` holds the accumulator, counter and HI/LO registers, with a start/done handshake.
- `alu_issue` holds the decode logic, the FSM and the stall generation.

## Test plan
- Decode sweep:
  - `alu_op`=10 with funct 0x20/0x22/0x24/0x25/0x2A → `alu_signal` 010/011/000/001/100, `stall`=0.
  - funct 0x3F → ADD, `illegal`=1.
  - `alu_op` 00 → 010 and `alu_op` 01 → 011 for any funct.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - `stall` high for exactly 33 cycles.
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - `mul_done` is a single pulse.
- MULTU 0x00010000×0x00010000 → `hi`=1, `lo`=0; then MFHI → `hilo_sel`=01, and MFLO → 10.
- `rst` pulsed at BUSY count 10:
  - `stall`, `hi` and `lo` drop to 0 immediately, without waiting for a clock edge.
  - A following MULTU 3×5 gives `lo`=15, `hi`=0.
- Back-to-back MULTU 7×6 then 0×0x12345678:
  - Results 42 then 0.
  - The second MULTU is accepted in the cycle after DONE.
  - The first MULTU is not re-executed during DONE.
- MULTU 0x80000000×2 → `hi`=1, `lo`=0, confirming the carry bit is used.
